serial_adder: RTL and testbench

- Parametrised multi-cycle adder/subtractor. Successor to the single-bit full adders (dataflow, behavioural, case).
- Processes WIDTH-bit operands DIGIT bits per clock, keeping the carry in a flip-flop between digits.
- Trades latency for area in datapaths that do not need a single-cycle adder.
- Uses a start/busy/done handshake.

---
 rtl/serial_adder.sv | 141 ++++++++++++++
 tb/tb_serial_adder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: WIDTH/DIGIT cycles per op, carry kept in a flop; optional ovf port via SERIAL_ADDER_OVF_EN.
// Latency N=WIDTH/DIGIT edges from accepted start to done; start is ignored while busy (no queueing).
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               carry_q, carry_d;
  logic               co_q, co_d;
  logic               done_q, done_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DIGIT:0]     dsum;
  logic [WIDTH+DIGIT-1:0] res_wide;
`ifdef SERIAL_ADDER_OVF_EN
  logic               ovf_q, ovf_d;
  logic               msb_cin;
`endif

  // One digit of the sum; the result register fills from the MSB end.
  always_comb begin
    dsum     = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    res_wide = {dsum[DIGIT-1:0], res_q};
  end

`ifdef SERIAL_ADDER_OVF_EN
  // Carry into the digit MSB recovered from its sum bit and operand bits.
  assign msb_cin = dsum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    s_d     = s_q;
    carry_d = carry_q;
    co_d    = co_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub | ci;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        res_d   = res_wide[WIDTH+DIGIT-1:DIGIT];
        carry_d = dsum[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = IDLE;
          s_d     = res_wide[WIDTH+DIGIT-1:DIGIT];
          co_d    = dsum[DIGIT];
          done_d  = 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = msb_cin ^ dsum[DIGIT];
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign s    = s_q;
  assign co   = co_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: 8-bit DIGIT 1/4 instances plus exhaustive 4-bit DIGIT 1/2/4 instances.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] st;
  logic [7:0] a, b;
  logic       ci, sub;

  logic bz0, bz1, bz2, bz3, bz4;
  logic d0, d1, d2, d3, d4;
  logic c0, c1, c2, c3, c4;
  logic [7:0] s0, s1;
  logic [3:0] s2, s3, s4;
  logic [4:0] busy_v, done_v, co_v;
  logic [4:0][7:0] s_v;

  assign busy_v = {bz4, bz3, bz2, bz1, bz0};
  assign done_v = {d4, d3, d2, d1, d0};
  assign co_v   = {c4, c3, c2, c1, c0};
  assign s_v[0] = s0;
  assign s_v[1] = s1;
  assign s_v[2] = {4'h0, s2};
  assign s_v[3] = {4'h0, s3};
  assign s_v[4] = {4'h0, s4};

`ifdef SERIAL_ADDER_OVF_EN
  logic o0, o1, o2, o3, o4;
  logic [4:0] ovf_v;
  assign ovf_v = {o4, o3, o2, o1, o0};
`endif

  serial_adder #(.WIDTH(8), .DIGIT(1)) u0 (
    .clk(clk), .rst(rst), .start(st[0]), .a(a), .b(b), .ci(ci), .sub(sub),
    .busy(bz0), .done(d0), .s(s0), .co(c0)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(o0)
`endif
  );
  serial_adder #(.WIDTH(8), .DIGIT(4)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .a(a), .b(b), .ci(ci), .sub(sub),
    .busy(bz1), .done(d1), .s(s1), .co(c1)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(o1)
`endif
  );
  serial_adder #(.WIDTH(4), .DIGIT(1)) u2 (
    .clk(clk), .rst(rst), .start(st[2]), .a(a[3:0]), .b(b[3:0]), .ci(ci), .sub(sub),
    .busy(bz2), .done(d2), .s(s2), .co(c2)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(o2)
`endif
  );
  serial_adder #(.WIDTH(4), .DIGIT(2)) u3 (
    .clk(clk), .rst(rst), .start(st[3]), .a(a[3:0]), .b(b[3:0]), .ci(ci), .sub(sub),
    .busy(bz3), .done(d3), .s(s3), .co(c3)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(o3)
`endif
  );
  serial_adder #(.WIDTH(4), .DIGIT(4)) u4 (
    .clk(clk), .rst(rst), .start(st[4]), .a(a[3:0]), .b(b[3:0]), .ci(ci), .sub(sub),
    .busy(bz4), .done(d4), .s(s4), .co(c4)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(o4)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Present operands and pulse start for exactly one rising edge.
  task automatic kick(input int idx, input logic [7:0] av, input logic [7:0] bv,
                      input logic civ, input logic subv);
    @(negedge clk);
    a = av; b = bv; ci = civ; sub = subv;
    st[idx] = 1'b1;
    @(posedge clk);
    #1 st[idx] = 1'b0;
  endtask

  // Counts rising edges until done is seen; bounded so a dead DUT still reaches the summary.
  task automatic wait_done(input int idx, input string tag, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (done_v[idx] !== 1'b1 && cyc < 40);
    chk({tag, "_done"}, {31'd0, done_v[idx]}, 32'd1);
  endtask

  task automatic run(input int idx, input string tag, input logic [7:0] av, input logic [7:0] bv,
                     input logic civ, input logic subv,
                     output logic [7:0] rs, output logic rc, output int lat);
    kick(idx, av, bv, civ, subv);
    wait_done(idx, tag, lat);
    rs = s_v[idx];
    rc = co_v[idx];
  endtask

  task automatic count_pulses(input int idx, input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_v[idx] === 1'b1) pulses++;
    end
  endtask

  initial begin
    logic [7:0] rs;
    logic       rc;
    int         lat;
    int         pulses;
    logic [3:0] av, bv, es;
    logic [4:0] esum;
    logic       civ, subv, ec, eovf;

    rst = 1'b1; st = '0; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rst_busy%0d", i), {31'd0, busy_v[i]}, 32'd0);
      chk($sformatf("rst_done%0d", i), {31'd0, done_v[i]}, 32'd0);
      chk($sformatf("rst_s%0d", i), {24'd0, s_v[i]}, 32'd0);
      chk($sformatf("rst_co%0d", i), {31'd0, co_v[i]}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      chk($sformatf("rst_ovf%0d", i), {31'd0, ovf_v[i]}, 32'd0);
`endif
    end
    rst = 1'b0;

    // FF + 01: wraps to 00 with carry out, 8 cycles.
    kick(0, 8'hFF, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    chk("add_busy", {31'd0, busy_v[0]}, 32'd1);
    wait_done(0, "add", lat);
    chk("add_lat", lat, 32'd8);
    chk("add_s", {24'd0, s_v[0]}, 32'h00);
    chk("add_co", {31'd0, co_v[0]}, 32'd1);
    chk("add_nobusy", {31'd0, busy_v[0]}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("add_done_drop", {31'd0, done_v[0]}, 32'd0);
    chk("add_s_hold", {24'd0, s_v[0]}, 32'h00);
    chk("add_co_hold", {31'd0, co_v[0]}, 32'd1);

    // Subtraction: ci must be ignored.
    run(0, "sub1", 8'h05, 8'h07, 1'b1, 1'b1, rs, rc, lat);
    chk("sub1_s", {24'd0, rs}, 32'hFE);
    chk("sub1_co", {31'd0, rc}, 32'd0);
    run(0, "sub2", 8'h07, 8'h05, 1'b0, 1'b1, rs, rc, lat);
    chk("sub2_s", {24'd0, rs}, 32'h02);
    chk("sub2_co", {31'd0, rc}, 32'd1);

    // 4-bit digits: 3C + 4B + 1 = 88, signed overflow.
    run(1, "dig4", 8'h3C, 8'h4B, 1'b1, 1'b0, rs, rc, lat);
    chk("dig4_lat", lat, 32'd2);
    chk("dig4_s", {24'd0, rs}, 32'h88);
    chk("dig4_co", {31'd0, rc}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("dig4_ovf", {31'd0, ovf_v[1]}, 32'd1);
`endif

    // Start while busy must not relatch.
    kick(0, 8'h10, 8'h20, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; st[0] = 1'b1;
    @(posedge clk);
    #1 st[0] = 1'b0;
    wait_done(0, "busy_start", lat);
    chk("busy_start_lat", lat, 32'd6);
    chk("busy_start_s", {24'd0, s_v[0]}, 32'h30);
    chk("busy_start_co", {31'd0, co_v[0]}, 32'd0);

    // Start on the done cycle is accepted immediately: 81 + 7F + 1 = 101.
    a = 8'h81; b = 8'h7F; ci = 1'b1; sub = 1'b0; st[0] = 1'b1;
    @(posedge clk);
    #1 st[0] = 1'b0;
    @(negedge clk);
    chk("b2b_busy", {31'd0, busy_v[0]}, 32'd1);
    chk("b2b_done_low", {31'd0, done_v[0]}, 32'd0);
    wait_done(0, "b2b", lat);
    chk("b2b_lat", lat, 32'd8);
    chk("b2b_s", {24'd0, s_v[0]}, 32'h01);
    chk("b2b_co", {31'd0, co_v[0]}, 32'd1);
    count_pulses(0, 12, pulses);
    chk("b2b_no_extra_done", pulses, 32'd0);

    // Reset in the middle of RUN aborts with no done pulse.
    kick(0, 8'h12, 8'h34, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", {31'd0, busy_v[0]}, 32'd0);
    chk("mid_rst_done", {31'd0, done_v[0]}, 32'd0);
    chk("mid_rst_s", {24'd0, s_v[0]}, 32'h00);
    chk("mid_rst_co", {31'd0, co_v[0]}, 32'd0);
    count_pulses(0, 12, pulses);
    chk("mid_rst_no_done", pulses, 32'd0);
    run(0, "after_rst", 8'h12, 8'h34, 1'b0, 1'b0, rs, rc, lat);
    chk("after_rst_lat", lat, 32'd8);
    chk("after_rst_s", {24'd0, rs}, 32'h46);
    chk("after_rst_co", {31'd0, rc}, 32'd0);

    // Exhaustive 4-bit: 512 add combinations then 256 subtractions per digit size.
    $display("ci a b | s co");
    for (int idx = 2; idx <= 4; idx++) begin
      for (int m = 0; m < 768; m++) begin
        av = m[7:4];
        bv = m[3:0];
        subv = (m >= 512);
        civ = subv ? m[0] : m[8];
        run(idx, $sformatf("ex%0d", idx), {4'h0, av}, {4'h0, bv}, civ, subv, rs, rc, lat);
        if (!subv) begin
          esum = {1'b0, av} + {1'b0, bv} + {4'd0, civ};
          es   = esum[3:0];
          ec   = esum[4];
          eovf = (av[3] == bv[3]) && (es[3] != av[3]);
        end else begin
          es   = av - bv;
          ec   = (av >= bv);
          eovf = (av[3] != bv[3]) && (es[3] != av[3]);
        end
        chk($sformatf("ex%0d_s_%0d", idx, m), {24'd0, rs}, {28'd0, es});
        chk($sformatf("ex%0d_co_%0d", idx, m), {31'd0, rc}, {31'd0, ec});
`ifdef SERIAL_ADDER_OVF_EN
        chk($sformatf("ex%0d_ovf_%0d", idx, m), {31'd0, ovf_v[idx]}, {31'd0, eovf});
`endif
        if (idx == 2 && !subv)
          $display(" %b %h %h | %h %b", civ, av, bv, rs[3:0], rc);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
